// File: rtl/lag_window_fsm_pkg.sv
// Shared constants and state encoding for the lag-window sequencer.
package lag_window_fsm_pkg;

  // LPC order: number of lag-windowed coefficients r[1..M]
  localparam int M = 10;

  // Index value of the final coefficient, sized to the loop counter
  localparam logic [3:0] LAST_INDEX = 4'(M);

  // Base address of r[0..M]; low nibble must be zero because the
  // coefficient index is concatenated onto the upper address bits
  localparam logic [11:0] AUTOCORR_R = 12'h040;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MUL   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lag_window_rom.sv
// Combinational lag-window table: index i-1 returns {lag_h, lag_l}.
module lag_window_rom (
  input  logic [3:0]  index,
  output logic [31:0] lag
);

  // Constant lookup; unused indices return zero
  always_comb begin
    lag = 32'd0;
    case (index)
      4'd0:    lag = {16'd32728, 16'd11904};
      4'd1:    lag = {16'd32619, 16'd17280};
      4'd2:    lag = {16'd32438, 16'd30720};
      4'd3:    lag = {16'd32187, 16'd25856};
      4'd4:    lag = {16'd31867, 16'd24192};
      4'd5:    lag = {16'd31480, 16'd28992};
      4'd6:    lag = {16'd31029, 16'd24384};
      4'd7:    lag = {16'd30517, 16'd7360};
      4'd8:    lag = {16'd29946, 16'd19520};
      4'd9:    lag = {16'd29321, 16'd14784};
      default: lag = 32'd0;
    endcase
  end

endmodule

// File: rtl/lag_window_fsm.sv
// G.729 Lag_window sequencer: reads r[1..M] from scratch memory, applies
// Mpy_32 with the lag table and L_Extract, and writes each result in place.
module lag_window_fsm
  import lag_window_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [31:0] memIn,
  output logic [11:0] readRequested,
  output logic [11:0] writeRequested,
  output logic        writeEn,
  output logic [31:0] memOut,
  output logic        done
);

  state_t state;
  state_t state_next;

  logic [3:0]         i;
  logic signed [31:0] hh;
  logic signed [15:0] c1;
  logic signed [15:0] c2;

  logic [3:0]         rom_index;
  logic [31:0]        lag;
  logic signed [15:0] r_h;
  logic signed [15:0] r_l;
  logic signed [15:0] lag_h;
  logic signed [15:0] lag_l;
  logic [11:0]        coef_addr;
  logic signed [31:0] acc;

  // 32-bit saturating add (L_add)
  function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31]))
      return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s;
  endfunction

  // 32-bit saturating subtract (L_sub)
  function automatic logic signed [31:0] l_sub(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [31:0] s;
    s = a - b;
    if ((a[31] != b[31]) && (s[31] != a[31]))
      return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s;
  endfunction

  // Doubled 16x16 product, saturating only for -32768 * -32768 (L_mult)
  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    if (p == 32'sh4000_0000)
      return 32'h7FFF_FFFF;
    return p <<< 1;
  endfunction

  // Q15 product, saturating only for -32768 * -32768 (mult)
  function automatic logic signed [15:0] mult(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    if (p == 32'sh4000_0000)
      return 16'sh7FFF;
    return 16'(p >>> 15);
  endfunction

  lag_window_rom u_rom (
    .index (rom_index),
    .lag   (lag)
  );

  // Operand selection and the Mpy_32 accumulation that feeds the write
  always_comb begin
    rom_index = i - 4'd1;
    r_h       = memIn[31:16];
    r_l       = memIn[15:0];
    lag_h     = lag[31:16];
    lag_l     = lag[15:0];
    coef_addr = {AUTOCORR_R[11:4], i};
    acc       = l_add(l_add(hh, l_mult(c1, 16'sd1)), l_mult(c2, 16'sd1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Coefficient index and partial-product registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i  <= 4'd0;
      hh <= 32'sd0;
      c1 <= 16'sd0;
      c2 <= 16'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (ready)
            i <= 4'd1;
        end
        MUL: begin
          hh <= l_mult(r_h, lag_h);
          c1 <= mult(r_h, lag_l);
          c2 <= mult(r_l, lag_h);
        end
        WRITE: begin
          i <= i + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and Moore outputs; outputs are zero unless the state drives them
  always_comb begin
    state_next     = state;
    readRequested  = 12'd0;
    writeRequested = 12'd0;
    writeEn        = 1'b0;
    memOut         = 32'd0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (ready)
          state_next = READ;
      end
      READ: begin
        readRequested = coef_addr;
        state_next    = MUL;
      end
      MUL: begin
        state_next = WRITE;
      end
      WRITE: begin
        writeEn        = 1'b1;
        writeRequested = coef_addr;
        memOut         = {acc[31:16],
                          16'(l_sub(acc >>> 1, l_mult(acc[31:16], 16'sd16384)))};
        state_next     = (i == LAST_INDEX) ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lag_window_fsm.sv
// Scoreboard bench for lag_window_fsm with a memory model and an
// integer-arithmetic Lag_window reference.
module tb_lag_window_fsm;
  import lag_window_fsm_pkg::*;

  localparam logic [11:0] BASE = AUTOCORR_R;
  localparam int PASS_LEN = 3 * M + 2;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] memIn;
  logic [11:0] readRequested;
  logic [11:0] writeRequested;
  logic        writeEn;
  logic [31:0] memOut;
  logic        done;

  logic [31:0] mem [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] ref_r [1:M];
  exp_t        rd_q[$];
  exp_t        wr_q[$];
  int          done_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic end_req = 1'b0;
  logic nominal_watch = 1'b0;

  int lag_h_tab [0:9] = '{32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321};
  int lag_l_tab [0:9] = '{11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784};

  lag_window_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .memIn          (memIn),
    .readRequested  (readRequested),
    .writeRequested (writeRequested),
    .writeEn        (writeEn),
    .memOut         (memOut),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected events
  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory: one-cycle read latency, DUT writes, bench preloads
  always @(posedge clk) begin
    memIn <= mem[readRequested];
    if (writeEn)
      mem[writeRequested] <= memOut;
    else if (ld_en)
      mem[ld_addr] <= ld_data;
  end

  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint ref_l_mult(input longint a, input longint b);
    return sat32(2 * a * b);
  endfunction

  function automatic longint ref_mult(input longint a, input longint b);
    longint p;
    p = (a * b) >>> 15;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  // Mpy_32(r_h, r_l, lag_h, lag_l) followed by L_Extract, in plain integers
  function automatic logic [31:0] ref_word(input logic [31:0] w, input int k);
    longint rh, rl, lh, ll, acc, hi, lo;
    rh  = longint'($signed(w[31:16]));
    rl  = longint'($signed(w[15:0]));
    lh  = longint'(lag_h_tab[k]);
    ll  = longint'(lag_l_tab[k]);
    acc = ref_l_mult(rh, lh);
    acc = sat32(acc + ref_l_mult(ref_mult(rh, ll), 1));
    acc = sat32(acc + ref_l_mult(ref_mult(rl, lh), 1));
    hi  = acc >>> 16;
    lo  = sat32((acc >>> 1) - ref_l_mult(hi, 16384));
    return {hi[15:0], lo[15:0]};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic note_unexpected(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %h at cycle %0d, expected no event", name, actual, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, write or done
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (reset) begin
      check_output("reset_outputs",
                   {6'd0, readRequested, writeRequested, writeEn, memOut, done}, 64'd0);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
    end else begin
      if (readRequested != 12'd0) begin
        if (rd_q.size() == 0) note_unexpected("read", {52'd0, readRequested});
        else begin
          e = rd_q.pop_front();
          check_output("read", {32'd0, cyc[15:0], 4'd0, readRequested},
                       {32'd0, e.cyc[15:0], 4'd0, e.addr});
        end
      end
      if (writeEn) begin
        if (wr_q.size() == 0) note_unexpected("write", {20'd0, writeRequested, memOut});
        else begin
          e = wr_q.pop_front();
          check_output("write", {4'd0, cyc[15:0], writeRequested, memOut},
                       {4'd0, e.cyc[15:0], e.addr, e.data});
        end
        if (nominal_watch && writeRequested == BASE + 12'd1)
          check_output("nominal_r1", {32'd0, memOut}, {32'd0, 32'h3FEC1740});
      end else begin
        check_output("write_bus_idle", {20'd0, writeRequested, memOut}, 64'd0);
      end
      if (done) begin
        if (done_q.size() == 0) note_unexpected("done", 64'd1);
        else begin
          d = done_q.pop_front();
          check_output("done_cycle", {32'd0, cyc}, {32'd0, d});
        end
      end
    end
    if (end_req || cyc > 50000) begin
      if (!end_req) note_unexpected("timeout", 64'(cyc));
      check_output("pending_reads", 64'(rd_q.size()), 64'd0);
      check_output("pending_writes", 64'(wr_q.size()), 64'd0);
      check_output("pending_done", 64'(done_q.size()), 64'd0);
      check_output("r0_untouched", {32'd0, mem[BASE]}, {32'd0, 32'hDEADBEEF});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Preload r[0..M]; r[0] gets a sentinel that must never change
  task automatic load_mem(input int mode);
    logic [31:0] w;
    for (int k = 0; k <= M; k++) begin
      if (k == 0) w = 32'hDEADBEEF;
      else begin
        case (mode)
          1: w = 32'd0;
          2: w = 32'h7FFF_FFFF;
          3: w = (k == 1) ? 32'h4000_0000 : $urandom;
          4: begin
            case ($urandom_range(0, 4))
              0: w = 32'h8000_0000;
              1: w = 32'h8000_8000;
              2: w = 32'h7FFF_8000;
              3: w = 32'h7FFF_FFFF;
              default: w = $urandom;
            endcase
          end
          default: w = $urandom;
        endcase
        ref_r[k] = w;
      end
      ld_addr = BASE + 12'(k);
      ld_data = w;
      ld_en   = 1'b1;
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // Push the expected reads, writes and done of one pass starting in cycle s
  task automatic push_pass(input int s);
    logic [11:0] a;
    logic [31:0] r;
    for (int k = 0; k < M; k++) begin
      a = {BASE[11:4], 4'(k + 1)};
      r = ref_word(ref_r[k + 1], k);
      rd_q.push_back('{s + 1 + 3 * k, a, 32'd0});
      wr_q.push_back('{s + 3 + 3 * k, a, r});
      ref_r[k + 1] = r;
    end
    done_q.push_back(s + 1 + 3 * M);
  endtask

  // Run n back-to-back passes; jitter randomises ready where it must be ignored
  task automatic apply_stimulus(input int n, input bit jitter);
    int s;
    s = cyc;
    for (int p = 0; p < n; p++) push_pass(s + PASS_LEN * p);
    for (int k = 0; k <= PASS_LEN * n; k++) begin
      if (k % PASS_LEN == 0) ready = (k < PASS_LEN * n);
      else ready = jitter ? 1'($urandom_range(0, 1)) : (n > 1);
      @(negedge clk);
    end
    ready = 1'b0;
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    reset   = 1'b1;
    ready   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 12'd0;
    ld_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    load_mem(3);
    nominal_watch = 1'b1;
    apply_stimulus(1, 1'b0);
    nominal_watch = 1'b0;

    load_mem(1);
    apply_stimulus(1, 1'b0);

    load_mem(2);
    apply_stimulus(1, 1'b0);

    load_mem(0);
    apply_stimulus(1, 1'b1);

    load_mem(0);
    begin
      int s;
      s = cyc;
      push_pass(s);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      while (cyc < s + 14) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
    end
    load_mem(0);
    apply_stimulus(1, 1'b0);

    load_mem(0);
    apply_stimulus(3, 1'b0);

    for (int t = 0; t < 4; t++) begin
      load_mem(4);
      apply_stimulus(1, 1'b1);
    end

    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule

// File: doc/lag_window_fsm.md
LAG_WINDOW_FSM -- requirements
Module: lag_window_fsm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, and the ports SHALL be named clk and reset.
REQ-002 Constant M, default 10: LPC order, the number of lag-windowed coefficients r[1..M].
REQ-003 Constant AUTOCORR_R, default from paramList: base address of r[0..M]; each word is {r_h[15:0], r_l[15:0]}.
REQ-004 Port clk, input, 1 bit: clock; all state changes occur on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 Port ready, input, 1 bit: start request from the sequencer, sampled only in IDLE.
REQ-007 Port memIn, input, 32 bits: scratch-memory read data, valid one cycle after readRequested is driven.
REQ-008 Port readRequested, output, 12 bits: scratch-memory read address.
REQ-009 Port writeRequested, output, 12 bits: scratch-memory write address.
REQ-010 Port writeEn, output, 1 bit: write strobe, one cycle per coefficient.
REQ-011 Port memOut, output, 32 bits: write data {r_h', r_l'}.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The block SHALL implement G.729 Lag_window: for i = 1..M, r[i] = Mpy_32(r_h[i], r_l[i], lag_h[i-1], lag_l[i-1]), followed by L_Extract, written in place; r[0] is never read or written.
REQ-014 FSM states: IDLE, READ, MUL, WRITE, DONE.
REQ-015 IDLE: if ready = 1, load i to 1 and go to READ; otherwise stay in IDLE.
REQ-016 READ: drive readRequested = {AUTOCORR_R[11:4], i[3:0]}, then go to MUL.
REQ-017 MUL: register hh = L_mult(r_h, lag_h), c1 = mult(r_h, lag_l) and c2 = mult(r_l, lag_h), where r_h = memIn[31:16] and r_l = memIn[15:0]; then go to WRITE.
REQ-018 WRITE:
- compute L = L_mac(L_mac(hh, c1, 1), c2, 1);
- drive writeEn = 1, writeRequested equal to the READ address, and memOut = {L[31:16], low 16 bits of L_msu(L>>1, L[31:16], 16384)};
- increment i;
- go to DONE if i was M, otherwise go to READ.
REQ-019 DONE: drive done = 1 for exactly one cycle, then go to IDLE.
REQ-020 Timing: ready sampled in cycle 0, ten READ/MUL/WRITE triplets occupy cycles 1-30, and done is high in cycle 31.
REQ-021 Arithmetic SHALL be bit-exact to the ITU basic operators:
- L_mult, mult, L_mac and L_msu use 16x16 signed products with saturation to 0x7FFFFFFF / 0x80000000 (32-bit) and 0x7FFF / 0x8000 (16-bit);
- L>>1 is an arithmetic shift.
REQ-022 ready SHALL be ignored outside IDLE; if ready is still high in the cycle after DONE, a new pass starts.
REQ-023 Outside their defined cycles, readRequested, writeRequested, memOut, writeEn and done SHALL be 0.

Reset
REQ-024 Asserting reset in any state SHALL immediately force state to IDLE, i to 0, all datapath registers to 0 and all outputs to 0.
REQ-025 Reset asserted mid-pass SHALL abort the pass with no further writes and no done pulse.

Structure
REQ-026 M, AUTOCORR_R and the state encodings SHALL be defined in paramList.
REQ-027 The lag table SHALL be a combinational sub-module lag_window_rom (4-bit index in, 32-bit {lag_h, lag_l} out) holding:
- lag_h = 32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321;
- lag_l = 11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784.
REQ-028 Saturating operators SHALL be local combinational functions; shared arithmetic units SHALL NOT be used.

Verification
REQ-029 Nominal: r[1] = 0x40000000, ready pulsed -> write to AUTOCORR_R+1 in cycle 3 with memOut = 0x3FEC1740.
REQ-030 All-zero r[1..10], ready pulsed -> 10 writes of 0x00000000 at cycles 3, 6, ..., 30, then done = 1 in cycle 31 only; r[0] is never accessed.
REQ-031 r[i] = 0x7FFFFFFF for all i -> every output equals a C-model Mpy_32/L_Extract reference, with no saturation mismatch.
REQ-032 Reset asserted in cycle 15 -> all outputs 0 the same cycle, no write after reset, no done pulse, and a new ready restarts the pass from i = 1.
REQ-033 ready held high continuously -> back-to-back passes with done pulses at cycles 31, 63, ..., and ready changes mid-pass have no effect.
